// File: rtl/ula_sequenciador.sv
// rtl/ula_sequenciador.sv - command FIFO plus sequencer that issues one ALU operation at a time
// Queues {op,a,b} commands, drives a registered-result ALU and returns its result with a handshake.
module ula_sequenciador #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [7:0]                    cmd_a,
    input  logic [7:0]                    cmd_b,
    input  logic [2:0]                    cmd_op,
    output logic [7:0]                    alu_a,
    output logic [7:0]                    alu_b,
    output logic [2:0]                    alu_op,
    input  logic [7:0]                    alu_s,
    input  logic                          alu_flag,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [7:0]                    res_s,
    output logic                          res_flag,
    output logic                          res_err,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        EMITE   = 3'd1,
        ESPERA  = 3'd2,
        COLETA  = 3'd3,
        ENTREGA = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [18:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ready_en;
    logic [18:0]     head;
    logic            head_legal;
    logic            push;
    logic            pop;
    logic            load_alu;
    logic            load_err;
    logic            cap_flag;
    logic            cap_s;
    logic            done;

    // ready_en keeps cmd_ready low during reset and until the first edge after release
    assign cmd_ready  = ready_en && (count < CW'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = mem[rd_ptr];
    assign head_legal = (head[18:16] <= 3'd4);
    assign fifo_count = count;
    assign busy       = (state != OCIOSO);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OCIOSO;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_alu   = 1'b0;
        load_err   = 1'b0;
        cap_flag   = 1'b0;
        cap_s      = 1'b0;
        done       = 1'b0;
        case (state)
            OCIOSO: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head_legal) begin
                        load_alu   = 1'b1;
                        state_next = EMITE;
                    end else begin
                        load_err   = 1'b1;
                        state_next = ENTREGA;
                    end
                end
            end
            EMITE:   state_next = ESPERA;
            ESPERA: begin
                cap_flag   = 1'b1;
                state_next = COLETA;
            end
            COLETA: begin
                cap_s      = 1'b1;
                state_next = ENTREGA;
            end
            ENTREGA: begin
                if (res_ready) begin
                    done       = 1'b1;
                    state_next = OCIOSO;
                end
            end
            default: state_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_s     <= '0;
            res_flag  <= 1'b0;
            res_err   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (load_alu) begin
                alu_op <= head[18:16];
                alu_a  <= head[15:8];
                alu_b  <= head[7:0];
            end
            // flag only carries meaning for add carry-out and sub borrow
            if (cap_flag) begin
                res_flag <= (alu_op == 3'd0 || alu_op == 3'd1) ? alu_flag : 1'b0;
            end
            if (cap_s) begin
                res_s     <= alu_s;
                res_err   <= 1'b0;
                res_valid <= 1'b1;
            end
            if (load_err) begin
                res_s     <= '0;
                res_flag  <= 1'b0;
                res_err   <= 1'b1;
                res_valid <= 1'b1;
            end
            if (done) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ula_sequenciador.sv
// tb/tb_ula_sequenciador.sv - randomized and directed bench for ula_sequenciador
// Holds a behavioural ALU and a transaction-level queue model of the sequencer.
module tb_ula_sequenciador;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_s;
    logic        alu_flag;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_s;
    logic        res_flag;
    logic        res_err;
    logic        busy;
    logic [2:0]  fifo_count;

    int checks = 0;
    int failures = 0;

    ula_sequenciador #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_s(alu_s), .alu_flag(alu_flag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_s(res_s), .res_flag(res_flag), .res_err(res_err),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // {flag, s} for a {op, a, b} command; flag is junk for logic ops so the DUT must mask it
    function automatic logic [8:0] ref_alu(input logic [18:0] c);
        logic [7:0] a;
        logic [7:0] b;
        a = c[15:8];
        b = c[7:0];
        case (c[18:16])
            3'd0:    ref_alu = {1'b0, a} + {1'b0, b};
            3'd1:    ref_alu = {(a < b), 8'(a - b)};
            3'd2:    ref_alu = {a[0], a & b};
            3'd3:    ref_alu = {~a[0], a | b};
            3'd4:    ref_alu = {1'b1, a ^ b};
            default: ref_alu = {b[7], a};
        endcase
    endfunction

    logic [8:0] alu_cur;
    assign alu_cur  = ref_alu({alu_op, alu_a, alu_b});
    assign alu_flag = alu_cur[8];
    always @(posedge clk) alu_s <= alu_cur[7:0];

    logic [18:0] mq[$];
    bit          m_ready_en;
    int          m_wait;
    logic [8:0]  m_pend;
    bit          m_rv;
    logic [7:0]  m_rs;
    bit          m_rf;
    bit          m_re;
    logic [7:0]  m_aa;
    logic [7:0]  m_ab;
    logic [2:0]  m_aop;
    int          n_acc;
    logic [9:0]  obs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ready_en = 1'b0;
        m_wait = 0;
        m_rv = 1'b0;
        m_rs = '0;
        m_rf = 1'b0;
        m_re = 1'b0;
        m_aa = '0;
        m_ab = '0;
        m_aop = '0;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_alu", {13'd0, alu_op, alu_a, alu_b}, 0);
        check("rst_res", {21'd0, res_valid, res_err, res_flag, res_s}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_cmd_ready", 32'(cmd_ready), 0);
        @(posedge clk);
        m_ready_en = 1'b1;
    endtask

    task automatic cycle(input bit v, input logic [18:0] c, input bit rr);
        bit acc;
        logic [18:0] h;
        @(negedge clk);
        check("cmd_ready", 32'(cmd_ready), 32'(m_ready_en && (mq.size() < DEPTH)));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("busy", 32'(busy), 32'((m_wait > 0) || m_rv));
        check("res_valid", 32'(res_valid), 32'(m_rv));
        check("alu_pins", {13'd0, alu_op, alu_a, alu_b}, {13'd0, m_aop, m_aa, m_ab});
        if (m_rv) begin
            check("res_bits", {22'd0, res_err, res_flag, res_s}, {22'd0, m_re, m_rf, m_rs});
            if (rr) obs.push_back({res_err, res_flag, res_s});
        end
        cmd_valid = v;
        {cmd_op, cmd_a, cmd_b} = c;
        res_ready = rr;
        @(posedge clk);
        acc = v && m_ready_en && (mq.size() < DEPTH);
        if (m_rv) begin
            if (rr) m_rv = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_rv = 1'b1;
                {m_rf, m_rs} = m_pend;
                m_re = 1'b0;
            end
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h[18:16] <= 3'd4) begin
                {m_aop, m_aa, m_ab} = h;
                m_wait = 3;
                m_pend = ref_alu(h);
                if (h[18:16] > 3'd1) m_pend[8] = 1'b0;
            end else begin
                m_rv = 1'b1;
                m_rs = '0;
                m_rf = 1'b0;
                m_re = 1'b1;
            end
        end
        if (acc) begin
            mq.push_back(c);
            n_acc++;
        end
        m_ready_en = 1'b1;
    endtask

    logic [18:0] dir_cmd [5];
    logic [9:0]  dir_exp [5];

    initial begin
        dir_cmd[0] = {3'd0, 8'hF0, 8'h20}; dir_exp[0] = {2'b01, 8'h10};
        dir_cmd[1] = {3'd1, 8'h05, 8'h07}; dir_exp[1] = {2'b01, 8'hFE};
        dir_cmd[2] = {3'd1, 8'h07, 8'h05}; dir_exp[2] = {2'b00, 8'h02};
        dir_cmd[3] = {3'd6, 8'hAA, 8'h0F}; dir_exp[3] = {2'b10, 8'h00};
        dir_cmd[4] = {3'd2, 8'hAA, 8'h0F}; dir_exp[4] = {2'b00, 8'h0A};

        model_reset();
        do_reset();

        // known-answer sequence, including an illegal opcode between legal ones
        obs.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, dir_cmd[i], 1'b1);
        repeat (30) cycle(1'b0, '0, 1'b1);
        check("dir_count", obs.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < obs.size()) check($sformatf("dir_res%0d", i), 32'(obs[i]), 32'(dir_exp[i]));
        end

        // fill the FIFO behind one in-flight op with results blocked
        do_reset();
        n_acc = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, {3'(i % 5), 8'(i * 17), 8'(i + 3)}, 1'b0);
        #1;
        check("full_count", 32'(fifo_count), 4);
        check("full_ready", 32'(cmd_ready), 0);
        check("full_accepted", n_acc, 5);
        repeat (40) cycle(1'b0, '0, 1'b1);

        // hold a result in ENTREGA with res_ready low
        cycle(1'b1, {3'd0, 8'h81, 8'h90}, 1'b0);
        cycle(1'b1, {3'd4, 8'h3C, 8'hFF}, 1'b0);
        repeat (14) cycle(1'b0, '0, 1'b0);
        repeat (12) cycle(1'b0, '0, 1'b1);

        // reset while in ESPERA with two commands queued
        cycle(1'b1, {3'd3, 8'h11, 8'h22}, 1'b0);
        cycle(1'b1, {3'd0, 8'h33, 8'h44}, 1'b0);
        cycle(1'b1, {3'd1, 8'h55, 8'h66}, 1'b0);
        #1;
        check("esp_count", 32'(fifo_count), 2);
        check("esp_busy", 32'(busy), 1);
        do_reset();
        repeat (10) cycle(1'b0, '0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cycle(1'($urandom_range(0, 1)),
                  {3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)},
                  ($urandom_range(0, 9) < 6));
        end
        repeat (30) cycle(1'b0, '0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
